// File: rtl/ex_stage_if.sv
// Execute-stage bundle: decoded operands and control in, registered results out.
// The stage itself takes the slave view; whoever feeds it takes the master view.
interface ex_stage_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] PC_out;
   logic [3:0]      alu_op;
   logic            alu_src;
   logic            branch;
   logic            jump;
   logic            jump_reg;
   logic [XLEN-1:0] ALU_result;
   logic [XLEN-1:0] rs2_forward;
   logic [XLEN-1:0] PC_target;
   logic            Branch_taken;

   modport master (
      output rs1_data, rs2_data, imm, PC_out, alu_op, alu_src, branch, jump, jump_reg,
      input  ALU_result, rs2_forward, PC_target, Branch_taken
   );

   modport slave (
      input  rs1_data, rs2_data, imm, PC_out, alu_op, alu_src, branch, jump, jump_reg,
      output ALU_result, rs2_forward, PC_target, Branch_taken
   );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU plus next-PC/redirect selection, all outputs registered (1-cycle latency).
// No backpressure: a new input set is taken on every rising clk edge.
module ex_stage #(
   parameter int XLEN = 32
) (
   input logic     clk,
   input logic     rst_n,
   ex_stage_if.slave bus
);
   localparam int SHW = $clog2(XLEN);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SLL  = 4'b0101,
      OP_SRL  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001
   } alu_op_t;

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;
   logic            zero;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] pc_rel;
   logic [XLEN-1:0] pc_seq;
   logic [XLEN-1:0] next_target;
   logic            next_taken;

   assign op_a  = bus.rs1_data;
   assign op_b  = bus.alu_src ? bus.imm : bus.rs2_data;
   assign shamt = op_b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (alu_op_t'(bus.alu_op))
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = op_a << shamt;
         OP_SRL:  alu_res = op_a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default: alu_res = '0;
      endcase
   end

   assign zero = (alu_res == '0);

   // Target adders are separate from the ALU so jumps never depend on alu_src/alu_op.
   assign jalr_sum = bus.rs1_data + bus.imm;
   assign pc_rel   = bus.PC_out + bus.imm;
   assign pc_seq   = bus.PC_out + XLEN'(4);

   always_comb begin
      next_target = pc_seq;
      next_taken  = 1'b0;
      if (bus.jump_reg) begin
         next_target = {jalr_sum[XLEN-1:1], 1'b0};
         next_taken  = 1'b1;
      end else if (bus.jump || (bus.branch && zero)) begin
         next_target = pc_rel;
         next_taken  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.ALU_result   <= '0;
         bus.rs2_forward  <= '0;
         bus.PC_target    <= '0;
         bus.Branch_taken <= 1'b0;
      end else begin
         bus.ALU_result   <= alu_res;
         bus.rs2_forward  <= bus.rs2_data;
         bus.PC_target    <= next_target;
         bus.Branch_taken <= next_taken;
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, a reset-in-stream sequence, then random
// stimulus against an arithmetic reference model.
module tb_ex_stage;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ex_stage_if #(.XLEN(32)) bus ();
   ex_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   typedef struct {
      logic        rst;
      logic [31:0] rs1, rs2, imm, pc;
      logic [3:0]  op;
      logic        src, br, j, jr;
      logic [31:0] e_alu, e_fwd, e_tgt;
      logic        e_taken;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n        = v.rst;
      bus.rs1_data = v.rs1;
      bus.rs2_data = v.rs2;
      bus.imm      = v.imm;
      bus.PC_out   = v.pc;
      bus.alu_op   = v.op;
      bus.alu_src  = v.src;
      bus.branch   = v.br;
      bus.jump     = v.j;
      bus.jump_reg = v.jr;
   endtask

   task automatic check_all(input string tag, input vec_t v);
      chk({tag, ".alu"},   bus.ALU_result,            v.e_alu);
      chk({tag, ".fwd"},   bus.rs2_forward,           v.e_fwd);
      chk({tag, ".tgt"},   bus.PC_target,             v.e_tgt);
      chk({tag, ".taken"}, {31'd0, bus.Branch_taken}, {31'd0, v.e_taken});
   endtask

   task automatic add(input logic rst, input logic [31:0] rs1, rs2, imm, pc, input logic [3:0] op,
                      input logic src, br, j, jr,
                      input logic [31:0] ea, ef, et, input logic etk);
      vec_t v;
      v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc; v.op = op;
      v.src = src; v.br = br; v.j = j; v.jr = jr;
      v.e_alu = ea; v.e_fwd = ef; v.e_tgt = et; v.e_taken = etk;
      tbl.push_back(v);
   endtask

   // Reference model: straight from the operation definitions.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      logic [31:0] ones;
      logic [31:0] msb;
      sh   = b % 32;
      ones = 32'hFFFF_FFFF;
      msb  = 32'h8000_0000;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << sh;
         4'd6: return a >> sh;
         4'd7: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
         4'd8: return ((a ^ msb) < (b ^ msb)) ? 32'd1 : 32'd0;
         4'd9: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic vec_t model(input vec_t v);
      vec_t r;
      logic [31:0] res;
      r = v;
      res = ref_alu(v.op, v.rs1, v.src ? v.imm : v.rs2);
      r.e_alu = res;
      r.e_fwd = v.rs2;
      if (v.jr) begin
         r.e_tgt = (v.rs1 + v.imm) & 32'hFFFF_FFFE; r.e_taken = 1'b1;
      end else if (v.j || (v.br && res == 32'd0)) begin
         r.e_tgt = v.pc + v.imm; r.e_taken = 1'b1;
      end else begin
         r.e_tgt = v.pc + 32'd4; r.e_taken = 1'b0;
      end
      if (!v.rst) begin
         r.e_alu = 0; r.e_fwd = 0; r.e_tgt = 0; r.e_taken = 0;
      end
      return r;
   endfunction

   initial begin
      vec_t v;
      //   rst rs1           rs2          imm           pc            op    src br j jr   alu           fwd          tgt           tk
      add(0, 32'd10,       32'd7,       32'd5,        32'd100,      4'd0, 0, 0, 0, 0, 32'd0,        32'd0,       32'd0,        0);
      add(1, 32'd10,       32'd7,       32'd5,        32'd100,      4'd0, 0, 0, 0, 0, 32'd17,       32'd7,       32'd104,      0);
      add(1, 32'd10,       32'd7,       32'd5,        32'd100,      4'd0, 1, 0, 0, 0, 32'd15,       32'd7,       32'd104,      0);
      add(1, 32'd10,       32'd7,       32'd16,       32'd100,      4'd1, 0, 1, 0, 0, 32'd3,        32'd7,       32'd104,      0);
      add(1, 32'd10,       32'd10,      32'd16,       32'd100,      4'd1, 0, 1, 0, 0, 32'd0,        32'd10,      32'd116,      1);
      add(1, 32'd1,        32'd2,       32'd32,       32'd100,      4'd0, 0, 0, 1, 0, 32'd3,        32'd2,       32'd132,      1);
      add(1, 32'd200,      32'd0,       32'd12,       32'd0,        4'd0, 1, 0, 0, 1, 32'd212,      32'd0,       32'd212,      1);
      add(1, 32'd5,        32'd3,       32'd8,        32'd50,       4'd0, 0, 1, 1, 1, 32'd8,        32'd3,       32'd12,       1);
      add(0, 32'd5,        32'd3,       32'd8,        32'd50,       4'd0, 0, 1, 1, 1, 32'd0,        32'd0,       32'd0,        0);
      add(1, 32'd0,        32'd0,       32'd0,        32'd32,       4'd0, 0, 0, 0, 0, 32'd0,        32'd0,       32'd36,       0);
      add(1, 32'd0,        32'd0,       32'd0,        32'hFFFFFFFC, 4'd0, 0, 0, 0, 0, 32'd0,        32'd0,       32'd0,        0);
      add(1, 32'd5,        32'd3,       32'd0,        32'd0,        4'hC, 0, 0, 0, 0, 32'd0,        32'd3,       32'd4,        0);
      add(1, 32'd7,        32'd9,       32'd0,        32'd0,        4'd1, 0, 0, 0, 1, 32'hFFFFFFFE, 32'd9,       32'd6,        1);
      add(1, 32'h80000000, 32'd4,       32'd0,        32'd0,        4'd7, 0, 0, 0, 0, 32'hF8000000, 32'd4,       32'd4,        0);
      add(1, 32'h80000000, 32'd36,      32'd0,        32'd0,        4'd6, 0, 0, 0, 0, 32'h08000000, 32'd36,      32'd4,        0);
      add(1, 32'hFFFFFFFF, 32'd1,       32'd0,        32'd0,        4'd8, 0, 0, 0, 0, 32'd1,        32'd1,       32'd4,        0);
      add(1, 32'hFFFFFFFF, 32'd1,       32'd0,        32'd0,        4'd9, 0, 0, 0, 0, 32'd0,        32'd1,       32'd4,        0);
      add(1, 32'd5,        32'd3,       32'hFFFFFFF8, 32'd100,      4'd9, 0, 1, 0, 0, 32'd0,        32'd3,       32'd92,       1);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i]);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), tbl[i]);
      end

      // Reset asserted for one edge in the middle of a held input set, then released.
      v = tbl[5];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         v.rst = (k != 1);
         drive(v);
         @(posedge clk);
         #1;
         check_all($sformatf("rstseq%0d", k), model(v));
      end

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         v.rst = ($urandom_range(0, 19) != 0);
         v.rs1 = $urandom;
         v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
         v.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
         v.pc  = $urandom;
         v.op  = 4'($urandom_range(0, 15));
         v.src = 1'($urandom);
         v.br  = 1'($urandom);
         v.j   = ($urandom_range(0, 3) == 0);
         v.jr  = ($urandom_range(0, 3) == 0);
         drive(v);
         @(posedge clk);
         #1;
         check_all($sformatf("rnd%0d", i), model(v));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
